spi_slave_mode: RTL and testbench
=================================

// Module: spi_slave_mode
// PURPOSE
//  Parametrised SPI slave: word width DATA_W, all four SPI modes (CPOL/CPHA) selectable at run time.
//  Oversamples ss_n/sck/mosi in the clk domain and moves words through valid/ready transmit and
//  valid-pulse receive interfaces.
//  Sits between the external host SPI pins and the command decoder; replaces the fixed 8-bit, mode-0 slave.
// PARAMETERS
//  DATA_W       8         bits per SPI word (>=2); MSB first.
//  SYNC_STAGES  2         flops per pin synchroniser (>=2).
//  FILL         all ones  DATA_W-bit word shifted out when no tx word is queued.
// PORTS
//  clk          in   1       system clock.
//  rst          in   1       synchronous reset, active-high.
//  ss_n         in   1       slave select, active-low, asynchronous pin.
//  sck          in   1       SPI clock pin, asynchronous.
//  mosi         in   1       SPI data in, asynchronous.
//  miso         out  1       SPI data out, registered.
//  cpol         in   1       clock polarity; latched at ss_n fall.
//  cpha         in   1       clock phase; latched at ss_n fall.
//  tx_data      in   DATA_W  next word to transmit.
//  tx_valid     in   1       tx_data valid.
//  tx_ready     out  1       holding register empty; word accepted on tx_valid&&tx_ready.
//  rx_data      out  DATA_W  last complete received word; holds until next word completes.
//  rx_valid     out  1       one-cycle pulse: rx_data updated.
//  tx_underrun  out  1       one-cycle pulse: FILL loaded because holding register was empty.
//  busy         out  1       synchronised ss_n low.
// BEHAVIOUR
//  Reset: miso=1, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0. Bit count 0. Holding empty. FSM IDLE.
//  Sync: all pin tests use synchronised copies. sck edge = synced value differs from its previous-cycle copy.
//  Timing: sck high and low times each >= SYNC_STAGES+2 clk cycles.
//  FSM IDLE: miso=1; cpol/cpha tracked.
//  ss_n fall detected -> ACTIVE: latch mode, load shift reg (holding word, else FILL+tx_underrun), count=0.
//   CPHA=0: miso=shreg MSB in the same cycle as the ss_n fall is detected.
//  Leading edge = sck leaving cpol level; trailing = returning to it.
//   CPHA=0: sample on leading, shift/drive miso on trailing.
//   CPHA=1: drive miso on leading, sample on trailing.
//  Sample: shreg <= {shreg[DATA_W-2:0], mosi}; count++.
//   On the DATA_W-th sample: rx_data <= assembled word; rx_valid pulses the next cycle; count wraps to 0.
//   Same cycle: next tx word (holding or FILL) loaded into shreg.
//   CPHA=0 only: miso <= new MSB on the following trailing edge.
//  tx handshake: tx_ready=!holding_full. Holding register drains only at word load.
//   tx_valid accepted in the same cycle as a load -> not used for this word; held for the next word.
//   The word loaded is FILL and tx_underrun pulses.
//  rx has no back-pressure; the consumer must take rx_data within one word time.
//  ss_n rise mid-word -> IDLE: partial rx discarded (no rx_valid); count=0; miso=1.
//   A tx word already loaded into shreg counts as consumed. Holding register untouched.
//  Mode inputs ignored while ACTIVE.
//  rst mid-transfer: full reset; transfer resumes only after a fresh ss_n fall.
// CONFIGURATION
//  SPI_SLAVE_LSB_FIRST_EN defined: adds input port lsb_first (1 bit), latched at ss_n fall.
//   When 1: shift right, mosi enters at MSB, miso=shreg[0]; rx_data is bit-order-correct.
//  Not defined: no lsb_first port; MSB-first only.
// STRUCTURE
//  Package spi_pkg: typedef spi_mode_t {MODE0..MODE3}; typedef spis_state_t {IDLE, ACTIVE}; default FILL constant.
//  Sub-module spi_pin_sync (SYNC_STAGES-deep synchroniser plus previous-value flop).
//   One instance each for ss_n, sck, mosi.
//  Top: FSM, edge classification, shift register, bit counter, holding register.
// TESTING
//  Mode 0, DATA_W=8, tx 0xA5 queued.
//   Host sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse.
//  Modes 1,2,3 each: host sends 0x81, slave tx 0x7E -> host reads 0x7E, rx_data=0x81 in every mode.
//  No tx queued, 2 words -> host reads 0xFF,0xFF; tx_underrun pulses twice; tx_ready stays 1.
//  ss_n rise after 5 bits, then new transfer of 0x55 -> no rx_valid for the partial; second transfer rx_data=0x55.
//  DATA_W=16, back-to-back 0x1234,0xBEEF with tx_valid held high -> both words echoed in order.
//   tx_ready falls on accept and rises on load.
//  rst asserted mid-word, then new transfer -> outputs at reset values; next word received correctly.

Source files
------------

// File: rtl/spi_slave_mode_pkg.sv
// Shared types and constants for the SPI slave: SPI mode encoding, FSM states, default fill word.
package spi_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spis_state_t;

    localparam int unsigned      FILL_MAX_W   = 64;
    localparam logic [FILL_MAX_W-1:0] FILL_DEFAULT = '1;

endpackage

// File: rtl/spi_slave_mode_if.sv
// Word-level transmit (valid/ready) and receive (valid pulse) interface of the SPI slave.
interface spi_slave_mode_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport slave  (input  tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
    modport master (output tx_data, tx_valid, input  tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave_mode_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, plus a copy of the previous synced value.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_pin,
    output logic o_sync,
    output logic o_prev
);
    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        r_chain <= {r_chain[SYNC_STAGES-2:0], i_pin};
        r_prev  <= r_chain[SYNC_STAGES-1];
    end

    assign o_sync = r_chain[SYNC_STAGES-1];
    assign o_prev = r_prev;
endmodule

// File: rtl/spi_slave_mode.sv
// SPI slave, DATA_W-bit words, run-time CPOL/CPHA, oversampled pins in the clk domain.
// Optional build macro SPI_SLAVE_LSB_FIRST_EN adds the lsb_first port for LSB-first transfers.
module spi_slave_mode
    import spi_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL        = FILL_DEFAULT[DATA_W-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ss_n,
    input  logic             sck,
    input  logic             mosi,
    output logic             miso,
    input  logic             cpol,
    input  logic             cpha,
`ifdef SPI_SLAVE_LSB_FIRST_EN
    input  logic             lsb_first,
`endif
    spi_slave_mode_if.slave  bus,
    output logic             tx_underrun,
    output logic             busy
);
    localparam int         CNT_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_ACTIVE = ACTIVE;

    logic w_ss, w_ss_prev, w_sck, w_sck_prev, w_mosi, w_mosi_prev_unused;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss   (.clk(clk), .i_pin(ss_n), .o_sync(w_ss),   .o_prev(w_ss_prev));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck  (.clk(clk), .i_pin(sck),  .o_sync(w_sck),  .o_prev(w_sck_prev));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .i_pin(mosi), .o_sync(w_mosi), .o_prev(w_mosi_prev_unused));

    logic [0:0]        r_state;
    spi_mode_t         r_mode;
    logic [CNT_W-1:0]  r_count;
    logic              r_miso, r_hold_full, r_rx_valid, r_underrun, r_busy;
    logic [DATA_W-1:0] r_shreg, r_hold, r_rx_data;
    logic              w_lsb, w_lsb_in;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    logic r_lsb;
    always_ff @(posedge clk) begin
        if (rst)                    r_lsb <= 1'b0;
        else if (r_state == ST_IDLE) r_lsb <= lsb_first;
    end
    assign w_lsb    = r_lsb;
    assign w_lsb_in = lsb_first;
`else
    assign w_lsb    = 1'b0;
    assign w_lsb_in = 1'b0;
`endif

    function automatic logic out_bit(input logic [DATA_W-1:0] word, input logic lsb);
        return lsb ? word[0] : word[DATA_W-1];
    endfunction

    // Edge classification relative to the latched idle clock level.
    logic w_active, w_ss_fall, w_ss_rise, w_sck_edge, w_lead, w_trail;
    logic w_sample, w_drive, w_last, w_start, w_load, w_accept;
    logic [DATA_W-1:0] w_next_word, w_shifted;

    assign w_active    = (r_state == ST_ACTIVE);
    assign w_ss_fall   = w_ss_prev & ~w_ss;
    assign w_ss_rise   = ~w_ss_prev & w_ss;
    assign w_sck_edge  = w_sck ^ w_sck_prev;
    assign w_lead      = w_sck_edge & (w_sck != r_mode[1]);
    assign w_trail     = w_sck_edge & (w_sck == r_mode[1]);
    assign w_sample    = w_active & ~w_ss_rise & (r_mode[0] ? w_trail : w_lead);
    assign w_drive     = w_active & ~w_ss_rise & (r_mode[0] ? w_lead : w_trail);
    assign w_last      = w_sample & (r_count == CNT_W'(DATA_W - 1));
    assign w_start     = ~w_active & w_ss_fall;
    assign w_load      = w_start | w_last;
    assign w_accept    = bus.tx_valid & ~r_hold_full;
    assign w_next_word = r_hold_full ? r_hold : FILL;
    assign w_shifted   = w_lsb ? {w_mosi, r_shreg[DATA_W-1:1]} : {r_shreg[DATA_W-2:0], w_mosi};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE0;
            r_count     <= '0;
            r_miso      <= 1'b1;
            r_hold_full <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_busy      <= 1'b0;
            r_rx_data   <= '0;
        end else begin
            r_busy     <= ~w_ss;
            r_rx_valid <= w_last;
            // A word arriving in the load cycle cannot be used for it: FILL goes out instead.
            r_underrun <= w_load & ~r_hold_full;
            if (w_accept)    r_hold_full <= 1'b1;
            else if (w_load) r_hold_full <= 1'b0;
            if (w_last)      r_rx_data   <= w_shifted;

            if (r_state == ST_IDLE) begin
                r_mode  <= spi_mode_t'({cpol, cpha});
                r_count <= '0;
                r_miso  <= 1'b1;
                if (w_ss_fall) begin
                    r_state <= ST_ACTIVE;
                    if (!cpha) r_miso <= out_bit(w_next_word, w_lsb_in);
                end
            end else if (w_ss_rise) begin
                r_state <= ST_IDLE;
                r_count <= '0;
                r_miso  <= 1'b1;
            end else begin
                if (w_sample) r_count <= w_last ? '0 : r_count + 1'b1;
                if (w_drive)  r_miso  <= out_bit(r_shreg, w_lsb);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load)        r_shreg <= w_next_word;
        else if (w_sample) r_shreg <= w_shifted;
        if (w_accept)      r_hold  <= bus.tx_data;
    end

    assign miso         = r_miso;
    assign bus.tx_ready = ~r_hold_full;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign tx_underrun  = r_underrun;
    assign busy         = r_busy;
endmodule

// File: tb/tb_spi_slave_mode.sv
// Self-checking bench: bit-banged SPI host against an 8-bit and a 16-bit slave sharing the pins.
module tb_spi_slave_mode;
    localparam int H = 6;

    logic clk = 1'b0, rst = 1'b1;
    logic ss_n = 1'b1, sck = 1'b0, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic miso8, miso16, und8, und16, busy8, busy16;

    spi_slave_mode_if #(.DATA_W(8))  if8 ();
    spi_slave_mode_if #(.DATA_W(16)) if16 ();

    always #5 clk = ~clk;

    spi_slave_mode #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .ss_n(ss_n), .sck(sck), .mosi(mosi), .miso(miso8),
        .cpol(cpol), .cpha(cpha),
`ifdef SPI_SLAVE_LSB_FIRST_EN
        .lsb_first(1'b0),
`endif
        .bus(if8), .tx_underrun(und8), .busy(busy8)
    );

    spi_slave_mode #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst), .ss_n(ss_n), .sck(sck), .mosi(mosi), .miso(miso16),
        .cpol(cpol), .cpha(cpha),
`ifdef SPI_SLAVE_LSB_FIRST_EN
        .lsb_first(1'b0),
`endif
        .bus(if16), .tx_underrun(und16), .busy(busy16)
    );

    int checks = 0, errors = 0;
    logic [15:0] txq8[$], txq16[$], rxq8[$], rxq16[$];
    int und_cnt8 = 0, und_snap8 = 0;
    int rdy_rise16 = 0, rdy_fall16 = 0, rdy_fall8 = 0;
    logic rdy8_d = 1'b1, rdy16_d = 1'b1;
    logic acc8, acc16;

    // Tx queue drivers and output monitors.
    always @(posedge clk) begin
        acc8  <= if8.tx_valid && if8.tx_ready;
        acc16 <= if16.tx_valid && if16.tx_ready;
    end

    always @(negedge clk) begin
        if (acc8 && txq8.size() > 0)   void'(txq8.pop_front());
        if (acc16 && txq16.size() > 0) void'(txq16.pop_front());
        if8.tx_valid  = (txq8.size() > 0);
        if8.tx_data   = (txq8.size() > 0) ? txq8[0][7:0] : 8'h00;
        if16.tx_valid = (txq16.size() > 0);
        if16.tx_data  = (txq16.size() > 0) ? txq16[0] : 16'h0000;
        if (if8.rx_valid)  rxq8.push_back({8'h00, if8.rx_data});
        if (if16.rx_valid) rxq16.push_back(if16.rx_data);
        if (und8) und_cnt8++;
        if (if16.tx_ready && !rdy16_d) rdy_rise16++;
        if (!if16.tx_ready && rdy16_d) rdy_fall16++;
        if (!if8.tx_ready && rdy8_d)   rdy_fall8++;
        rdy16_d = if16.tx_ready;
        rdy8_d  = if8.tx_ready;
    end

    task automatic set_mode(input logic p, input logic h);
        cpol = p; cpha = h; sck = p;
        repeat (10) @(negedge clk);
    endtask

    task automatic ss_begin();
        ss_n = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic ss_end();
        ss_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic queue_tx(input bit wide, input logic [15:0] w);
        if (wide) txq16.push_back(w); else txq8.push_back(w);
        for (int k = 0; k < 20 && (wide ? txq16.size() : txq8.size()) > 0; k++) @(negedge clk);
        checks++;
        if ((wide ? txq16.size() : txq8.size()) != 0) begin
            errors++; $display("FAIL tx_accept pending=%0d required=0", wide ? txq16.size() : txq8.size());
        end
    endtask

    // Host side: MSB first, samples miso on the edge where the slave samples mosi.
    task automatic spi_word(input int nb, input logic [15:0] tx, input bit wide, output logic [15:0] rd);
        rd = '0;
        for (int i = nb - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = tx[i];
                repeat (H) @(negedge clk);
                sck = ~cpol;
                rd = {rd[14:0], wide ? miso16 : miso8};
                if (i == 0) und_snap8 = und_cnt8;
                repeat (H) @(negedge clk);
                sck = cpol;
            end else begin
                sck = ~cpol;
                mosi = tx[i];
                repeat (H) @(negedge clk);
                sck = cpol;
                rd = {rd[14:0], wide ? miso16 : miso8};
                if (i == 0) und_snap8 = und_cnt8;
                repeat (H) @(negedge clk);
            end
        end
        if (!cpha) repeat (H) @(negedge clk);
    endtask

    task automatic check_outputs_reset(input string tag);
        checks++; if (miso8 !== 1'b1)          begin errors++; $display("FAIL %s_miso got %b exp 1", tag, miso8); end
        checks++; if (if8.tx_ready !== 1'b1)   begin errors++; $display("FAIL %s_tx_ready got %b exp 1", tag, if8.tx_ready); end
        checks++; if (if8.rx_data !== 8'h00)   begin errors++; $display("FAIL %s_rx_data got %h exp 00", tag, if8.rx_data); end
        checks++; if (if8.rx_valid !== 1'b0)   begin errors++; $display("FAIL %s_rx_valid got %b exp 0", tag, if8.rx_valid); end
        checks++; if (und8 !== 1'b0)           begin errors++; $display("FAIL %s_underrun got %b exp 0", tag, und8); end
        checks++; if (busy8 !== 1'b0)          begin errors++; $display("FAIL %s_busy got %b exp 0", tag, busy8); end
    endtask

    task automatic test_reset();
        repeat (10) @(negedge clk);
        check_outputs_reset("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [15:0] rd;
        set_mode(1'b0, 1'b0);
        rxq8.delete();
        queue_tx(1'b0, 16'h00A5);
        ss_begin();
        spi_word(8, 16'h003C, 1'b0, rd);
        ss_end();
        checks++; if (rd[7:0] !== 8'hA5)  begin errors++; $display("FAIL mode0_miso got %h exp a5", rd[7:0]); end
        checks++; if (rxq8.size() != 1)   begin errors++; $display("FAIL mode0_rx_count got %0d exp 1", rxq8.size()); end
        else begin
            checks++; if (rxq8[0] !== 16'h003C) begin errors++; $display("FAIL mode0_rx_data got %h exp 3c", rxq8[0]); end
        end
    endtask

    task automatic one_xfer(input string tag, input int m, input bit do_tx, input logic [7:0] txw, input logic [7:0] host);
        logic [15:0] rd;
        logic [7:0]  exp_rd;
        set_mode(m[1], m[0]);
        rxq8.delete();
        if (do_tx) queue_tx(1'b0, {8'h00, txw});
        exp_rd = do_tx ? txw : 8'hFF;
        ss_begin();
        spi_word(8, {8'h00, host}, 1'b0, rd);
        ss_end();
        checks++; if (rd[7:0] !== exp_rd) begin errors++; $display("FAIL %s_m%0d_miso got %h exp %h", tag, m, rd[7:0], exp_rd); end
        checks++; if (rxq8.size() != 1)   begin errors++; $display("FAIL %s_m%0d_rx_count got %0d exp 1", tag, m, rxq8.size()); end
        else begin
            checks++; if (rxq8[0][7:0] !== host) begin errors++; $display("FAIL %s_m%0d_rx_data got %h exp %h", tag, m, rxq8[0][7:0], host); end
        end
    endtask

    task automatic test_modes();
        for (int m = 1; m <= 3; m++) one_xfer("modes", m, 1'b1, 8'h7E, 8'h81);
        for (int k = 0; k < 6; k++)
            one_xfer("rand", int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_underrun();
        logic [15:0] rd1, rd2;
        int base_und, base_fall;
        set_mode(1'b0, 1'b0);
        rxq8.delete();
        base_und  = und_cnt8;
        base_fall = rdy_fall8;
        ss_begin();
        spi_word(8, 16'h0012, 1'b0, rd1);
        spi_word(8, 16'h0034, 1'b0, rd2);
        ss_end();
        checks++; if (rd1[7:0] !== 8'hFF) begin errors++; $display("FAIL underrun_w1 got %h exp ff", rd1[7:0]); end
        checks++; if (rd2[7:0] !== 8'hFF) begin errors++; $display("FAIL underrun_w2 got %h exp ff", rd2[7:0]); end
        checks++; if (und_snap8 - base_und != 2) begin errors++; $display("FAIL underrun_pulses got %0d exp 2", und_snap8 - base_und); end
        checks++; if (rdy_fall8 != base_fall)  begin errors++; $display("FAIL underrun_ready_fell got %0d exp 0", rdy_fall8 - base_fall); end
        checks++; if (rxq8.size() != 2)        begin errors++; $display("FAIL underrun_rx_count got %0d exp 2", rxq8.size()); end
    endtask

    task automatic test_abort();
        logic [15:0] rd;
        set_mode(1'b0, 1'b0);
        rxq8.delete();
        ss_begin();
        spi_word(5, 16'h0015, 1'b0, rd);
        ss_end();
        checks++; if (rxq8.size() != 0) begin errors++; $display("FAIL abort_partial_rx got %0d exp 0", rxq8.size()); end
        ss_begin();
        spi_word(8, 16'h0055, 1'b0, rd);
        ss_end();
        checks++; if (rxq8.size() != 1) begin errors++; $display("FAIL abort_rx_count got %0d exp 1", rxq8.size()); end
        else begin
            checks++; if (rxq8[0] !== 16'h0055) begin errors++; $display("FAIL abort_rx_data got %h exp 55", rxq8[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd1, rd2;
        int base_rise, base_fall;
        set_mode(1'b1, 1'b1);
        rxq16.delete();
        base_rise = rdy_rise16;
        base_fall = rdy_fall16;
        txq16.push_back(16'h1234);
        txq16.push_back(16'hBEEF);
        repeat (5) @(negedge clk);
        checks++; if (if16.tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held got %b exp 0", if16.tx_ready); end
        ss_begin();
        spi_word(16, 16'h1234, 1'b1, rd1);
        spi_word(16, 16'hBEEF, 1'b1, rd2);
        ss_end();
        checks++; if (rd1 !== 16'h1234) begin errors++; $display("FAIL b2b_miso1 got %h exp 1234", rd1); end
        checks++; if (rd2 !== 16'hBEEF) begin errors++; $display("FAIL b2b_miso2 got %h exp beef", rd2); end
        checks++; if (rxq16.size() != 2) begin errors++; $display("FAIL b2b_rx_count got %0d exp 2", rxq16.size()); end
        else begin
            checks++; if (rxq16[0] !== 16'h1234) begin errors++; $display("FAIL b2b_rx1 got %h exp 1234", rxq16[0]); end
            checks++; if (rxq16[1] !== 16'hBEEF) begin errors++; $display("FAIL b2b_rx2 got %h exp beef", rxq16[1]); end
        end
        checks++; if (rdy_rise16 - base_rise != 2) begin errors++; $display("FAIL b2b_ready_rises got %0d exp 2", rdy_rise16 - base_rise); end
        checks++; if (rdy_fall16 - base_fall != 2) begin errors++; $display("FAIL b2b_ready_falls got %0d exp 2", rdy_fall16 - base_fall); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        logic [7:0]  txw, host;
        set_mode(1'b0, 1'b0);
        rxq8.delete();
        ss_begin();
        spi_word(4, 16'h000A, 1'b0, rd);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_reset("rst_mid");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        spi_word(8, 16'h00C3, 1'b0, rd);
        checks++; if (rxq8.size() != 0) begin errors++; $display("FAIL rst_mid_no_resume got %0d exp 0", rxq8.size()); end
        ss_end();
        txw  = 8'($urandom);
        host = 8'($urandom);
        queue_tx(1'b0, {8'h00, txw});
        ss_begin();
        spi_word(8, {8'h00, host}, 1'b0, rd);
        ss_end();
        checks++; if (rd[7:0] !== txw) begin errors++; $display("FAIL rst_mid_miso got %h exp %h", rd[7:0], txw); end
        checks++; if (rxq8.size() != 1) begin errors++; $display("FAIL rst_mid_rx_count got %0d exp 1", rxq8.size()); end
        else begin
            checks++; if (rxq8[0][7:0] !== host) begin errors++; $display("FAIL rst_mid_rx_data got %h exp %h", rxq8[0][7:0], host); end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
